// File: rtl/prf_pkg.sv
// Types and width helpers shared by the physical register file, rename and the ROB.
package prf_pkg;

    localparam int NUM_PREGS_DEF = 64;
    localparam int DATA_W_DEF    = 32;

    // Index width for a register file with n entries. It never drops below 1 bit.
    function automatic int preg_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int PREG_W_DEF = preg_w(NUM_PREGS_DEF);

    typedef logic [PREG_W_DEF-1:0] preg_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/prf_ready_table.sv
// Per-preg ready scoreboard. Rename clears a bit, writeback sets it, and flush sets every bit.
module prf_ready_table
    import prf_pkg::*;
#(
    parameter  int NUM_PREGS  = 64,
    parameter  int NUM_OPS    = 8,
    parameter  int NUM_WR     = 3,
    parameter  int NUM_ALLOC  = 2,
    localparam int PREG_W     = preg_w(NUM_PREGS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_en,
    input  logic [NUM_WR-1:0]                 wr_valid_i,
    input  logic [NUM_WR-1:0][PREG_W-1:0]     wr_addr_i,
    input  logic [NUM_ALLOC-1:0]              alloc_valid_i,
    input  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_addr_i,
    input  logic [NUM_OPS-1:0][PREG_W-1:0]    rd_addr_i,
    output logic [NUM_OPS-1:0]                rd_ready_o
);

    localparam logic [PREG_W:0] LIMIT = (PREG_W+1)'(NUM_PREGS);

    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_d;

    function automatic logic in_range(input logic [PREG_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Allocation is applied after writeback so that alloc wins on the same preg. Flush overrides both.
    always_comb begin
        ready_d = ready_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_valid_i[w] && in_range(wr_addr_i[w])) ready_d[wr_addr_i[w]] = 1'b1;
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_valid_i[a] && alloc_addr_i[a] != '0 && in_range(alloc_addr_i[a]))
                ready_d[alloc_addr_i[a]] = 1'b0;
        end
        if (flush_en) ready_d = '1;
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) ready_q <= '1;
        else      ready_q <= ready_d;
    end

    always_comb begin
        rd_ready_o = '0;
        for (int r = 0; r < NUM_OPS; r++) begin
            if (rd_addr_i[r] == '0)          rd_ready_o[r] = 1'b1;
            else if (in_range(rd_addr_i[r])) rd_ready_o[r] = ready_q[rd_addr_i[r]];
        end
    end

endmodule

// File: rtl/phys_reg_file_sb.sv
// Physical register file with a ready scoreboard, write-to-read bypass, a hardwired p0
// and a sticky detector for write conflicts.
module phys_reg_file_sb
    import prf_pkg::*;
#(
    parameter  int NUM_PREGS = 64,
    parameter  int DATA_W    = 32,
    parameter  int NUM_RD    = 4,
    parameter  int NUM_WR    = 3,
    parameter  int NUM_ALLOC = 2,
    parameter  int BYPASS    = 1,
    localparam int PREG_W    = preg_w(NUM_PREGS),
    localparam int NUM_OPS   = NUM_RD * 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_en,
    input  logic [NUM_OPS-1:0][PREG_W-1:0]    rd_addr_i,
    output logic [NUM_OPS-1:0][DATA_W-1:0]    rd_data_o,
    output logic [NUM_OPS-1:0]                rd_ready_o,
    input  logic [NUM_WR-1:0]                 wr_valid_i,
    input  logic [NUM_WR-1:0][PREG_W-1:0]     wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data_i,
    input  logic [NUM_ALLOC-1:0]              alloc_valid_i,
    input  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_addr_i,
    output logic                              wr_conflict_o
);

    localparam logic [PREG_W:0] LIMIT = (PREG_W+1)'(NUM_PREGS);

    logic [DATA_W-1:0]  mem_q [NUM_PREGS];
    logic [NUM_OPS-1:0] tbl_ready;
    logic               conflict_now;
    logic               conflict_q;

    function automatic logic in_range(input logic [PREG_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // The valid bits on the write and alloc ports have no back-pressure. An entry that is valid
    // at an edge is consumed at that edge.
    prf_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_OPS   (NUM_OPS),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC)
    ) u_ready (
        .clk           (clk),
        .rst           (rst),
        .flush_en      (flush_en),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .rd_addr_i     (rd_addr_i),
        .rd_ready_o    (tbl_ready)
    );

    always_comb begin
        conflict_now = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_valid_i[i] && wr_valid_i[j] && wr_addr_i[i] == wr_addr_i[j])
                    conflict_now = 1'b1;
            end
        end
    end

    // Writes are issued in ascending port order, so the highest port wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_valid_i[w] && wr_addr_i[w] != '0 && in_range(wr_addr_i[w]))
                    mem_q[wr_addr_i[w]] <= wr_data_i[w];
            end
            if (conflict_now) conflict_q <= 1'b1;
        end
    end

    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = tbl_ready;
        for (int r = 0; r < NUM_OPS; r++) begin
            if (rd_addr_i[r] != '0 && in_range(rd_addr_i[r])) begin
                rd_data_o[r] = mem_q[rd_addr_i[r]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_valid_i[w] && wr_addr_i[w] == rd_addr_i[r]) begin
                            rd_data_o[r]  = wr_data_i[w];
                            rd_ready_o[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign wr_conflict_o = conflict_q;

endmodule
